// File: rtl/lsu_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lsu_bus_sequencer
// Purpose  : Puts LSU loads/stores and fetch byte reads onto the 8-bit bus,
//            splitting 16-bit accesses into two little-endian byte cycles.
// Revision : 1.0  initial release
// ============================================================================
module lsu_bus_sequencer #(
    parameter logic DATA_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        a_rst,
    input  logic        rq_start,
    input  logic        rq_cmd,
    input  logic        rq_width,
    input  logic        rq_tag,
    input  logic [15:0] rq_adr,
    input  logic [15:0] rq_wdata,
    output logic        lsu_wait,
    output logic [15:0] lsu_data_out,
    output logic        lsu_data_tag,
    output logic        lsu_data_wb,
    input  logic        if_req,
    input  logic [15:0] if_adr,
    output logic        if_ack,
    output logic [7:0]  if_data,
    output logic [15:0] mem_adr,
    output logic [7:0]  mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic        mem_rdy,
    input  logic [7:0]  mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_D_LO  = 2'd1,
        S_D_HI  = 2'd2,
        S_FETCH = 2'd3
    } state_t;

    state_t      state_q;
    logic        cmd_q;
    logic        width_q;
    logic        tag_q;
    logic [7:0]  hi_byte_q;
    logic [7:0]  lo_byte_q;
    logic        data_acc;
    logic        fetch_acc;

    assign data_acc  = (state_q == S_IDLE) & rq_start & (DATA_FIRST | ~if_req);
    assign fetch_acc = (state_q == S_IDLE) & ~data_acc & if_req;
    assign lsu_wait  = rq_start & ~data_acc;

    // Strobes/address are registered alongside the state so they follow it exactly.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state_q      <= S_IDLE;
            cmd_q        <= 1'b0;
            width_q      <= 1'b0;
            tag_q        <= 1'b0;
            hi_byte_q    <= 8'h00;
            lo_byte_q    <= 8'h00;
            lsu_data_out <= 16'h0000;
            lsu_data_tag <= 1'b0;
            lsu_data_wb  <= 1'b0;
            if_ack       <= 1'b0;
            if_data      <= 8'h00;
            mem_adr      <= 16'h0000;
            mem_wdata    <= 8'h00;
            mem_rd       <= 1'b0;
            mem_wr       <= 1'b0;
        end else begin
            lsu_data_wb <= 1'b0;
            if_ack      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (data_acc) begin
                        state_q   <= S_D_LO;
                        cmd_q     <= rq_cmd;
                        width_q   <= rq_width;
                        tag_q     <= rq_tag;
                        hi_byte_q <= rq_wdata[15:8];
                        mem_adr   <= rq_adr;
                        mem_wdata <= rq_wdata[7:0];
                        mem_rd    <= ~rq_cmd;
                        mem_wr    <= rq_cmd;
                    end else if (fetch_acc) begin
                        state_q <= S_FETCH;
                        mem_adr <= if_adr;
                        mem_rd  <= 1'b1;
                    end
                end
                S_D_LO: begin
                    if (mem_rdy) begin
                        lo_byte_q <= mem_rdata;
                        if (width_q) begin
                            state_q   <= S_D_HI;
                            mem_adr   <= mem_adr + 16'd1;
                            mem_wdata <= hi_byte_q;
                        end else begin
                            state_q <= S_IDLE;
                            mem_rd  <= 1'b0;
                            mem_wr  <= 1'b0;
                            if (!cmd_q) begin
                                lsu_data_wb  <= 1'b1;
                                lsu_data_out <= {8'h00, mem_rdata};
                                lsu_data_tag <= tag_q;
                            end
                        end
                    end
                end
                S_D_HI: begin
                    if (mem_rdy) begin
                        state_q <= S_IDLE;
                        mem_rd  <= 1'b0;
                        mem_wr  <= 1'b0;
                        if (!cmd_q) begin
                            lsu_data_wb  <= 1'b1;
                            lsu_data_out <= {mem_rdata, lo_byte_q};
                            lsu_data_tag <= tag_q;
                        end
                    end
                end
                S_FETCH: begin
                    if (mem_rdy) begin
                        state_q <= S_IDLE;
                        mem_rd  <= 1'b0;
                        if_ack  <= 1'b1;
                        if_data <= mem_rdata;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_bus_sequencer
// Purpose  : Directed bench for lsu_bus_sequencer; index 0 has DATA_FIRST=1,
//            index 1 has DATA_FIRST=0. Load/fetch results go via scoreboards.
// Revision : 1.0  initial release
// ============================================================================
module tb_lsu_bus_sequencer;

    logic        clk = 1'b0;
    logic        a_rst = 1'b1;
    logic [1:0]  rq_start_v = 2'b00;
    logic [1:0]  if_req_v = 2'b00;
    logic        rq_cmd = 1'b0, rq_width = 1'b0, rq_tag = 1'b0;
    logic [15:0] rq_adr = 16'h0, rq_wdata = 16'h0, if_adr = 16'h0;
    logic        mem_rdy = 1'b1;

    logic [1:0]  lsu_wait_w, wb_w, tag_w, ack_w, rd_w, wr_w, if_req_eff;
    logic [15:0] data_w [2];
    logic [15:0] adr_w [2];
    logic [7:0]  ifd_w [2];
    logic [7:0]  wd_w [2];
    logic [7:0]  rdata_w [2];

    int n_tests = 0;
    int n_fail = 0;
    int wb_cnt [2];
    int ack_cnt [2];
    logic [16:0] ldq_a [$];
    logic [16:0] ldq_b [$];
    logic [7:0]  ifq_a [$];
    logic [7:0]  ifq_b [$];
    logic [16:0] e_ld_a, e_ld_b;
    logic [7:0]  e_if_a, e_if_b;

    always #5 clk = ~clk;

    // The fetch requester drops its request in the same cycle it sees the ack.
    assign if_req_eff = if_req_v & ~ack_w;

    function automatic logic [7:0] bus_byte(input logic [15:0] a);
        case (a)
            16'h1234: bus_byte = 8'hCD;
            16'h1235: bus_byte = 8'hAB;
            16'h0040: bus_byte = 8'h7F;
            default:  bus_byte = a[7:0] ^ a[15:8] ^ 8'h5A;
        endcase
    endfunction

    assign rdata_w[0] = bus_byte(adr_w[0]);
    assign rdata_w[1] = bus_byte(adr_w[1]);

    lsu_bus_sequencer #(.DATA_FIRST(1'b1)) dut_a (
        .clk(clk), .a_rst(a_rst), .rq_start(rq_start_v[0]), .rq_cmd(rq_cmd),
        .rq_width(rq_width), .rq_tag(rq_tag), .rq_adr(rq_adr), .rq_wdata(rq_wdata),
        .lsu_wait(lsu_wait_w[0]), .lsu_data_out(data_w[0]), .lsu_data_tag(tag_w[0]),
        .lsu_data_wb(wb_w[0]), .if_req(if_req_eff[0]), .if_adr(if_adr), .if_ack(ack_w[0]),
        .if_data(ifd_w[0]), .mem_adr(adr_w[0]), .mem_wdata(wd_w[0]), .mem_rd(rd_w[0]),
        .mem_wr(wr_w[0]), .mem_rdy(mem_rdy), .mem_rdata(rdata_w[0])
    );

    lsu_bus_sequencer #(.DATA_FIRST(1'b0)) dut_b (
        .clk(clk), .a_rst(a_rst), .rq_start(rq_start_v[1]), .rq_cmd(rq_cmd),
        .rq_width(rq_width), .rq_tag(rq_tag), .rq_adr(rq_adr), .rq_wdata(rq_wdata),
        .lsu_wait(lsu_wait_w[1]), .lsu_data_out(data_w[1]), .lsu_data_tag(tag_w[1]),
        .lsu_data_wb(wb_w[1]), .if_req(if_req_eff[1]), .if_adr(if_adr), .if_ack(ack_w[1]),
        .if_data(ifd_w[1]), .mem_adr(adr_w[1]), .mem_wdata(wd_w[1]), .mem_rd(rd_w[1]),
        .mem_wr(wr_w[1]), .mem_rdy(mem_rdy), .mem_rdata(rdata_w[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge: records handshakes, moves to just after the next posedge.
    task automatic adv();
        logic [1:0] acc, ack;
        acc = rq_start_v & ~lsu_wait_w;
        ack = ack_w;
        @(posedge clk);
        #1;
        rq_start_v = rq_start_v & ~acc;
        if_req_v   = if_req_v & ~ack;
    endtask

    task automatic push_ld(input logic [16:0] v);
        ldq_a.push_back(v);
        ldq_b.push_back(v);
    endtask

    task automatic push_if(input logic [7:0] v);
        ifq_a.push_back(v);
        ifq_b.push_back(v);
    endtask

    always @(negedge clk) begin
        if (wb_w[0]) begin
            wb_cnt[0]++;
            chk("A_wb_expected", ldq_a.size() > 0, 1);
            if (ldq_a.size() > 0) begin
                e_ld_a = ldq_a.pop_front();
                chk("A_load_result", {tag_w[0], data_w[0]}, e_ld_a);
            end
        end
        if (ack_w[0]) begin
            ack_cnt[0]++;
            chk("A_ack_expected", ifq_a.size() > 0, 1);
            if (ifq_a.size() > 0) begin
                e_if_a = ifq_a.pop_front();
                chk("A_fetch_data", ifd_w[0], e_if_a);
            end
        end
    end

    always @(negedge clk) begin
        if (wb_w[1]) begin
            wb_cnt[1]++;
            chk("B_wb_expected", ldq_b.size() > 0, 1);
            if (ldq_b.size() > 0) begin
                e_ld_b = ldq_b.pop_front();
                chk("B_load_result", {tag_w[1], data_w[1]}, e_ld_b);
            end
        end
        if (ack_w[1]) begin
            ack_cnt[1]++;
            chk("B_ack_expected", ifq_b.size() > 0, 1);
            if (ifq_b.size() > 0) begin
                e_if_b = ifq_b.pop_front();
                chk("B_fetch_data", ifd_w[1], e_if_b);
            end
        end
    end

    initial begin
        wb_cnt  = '{0, 0};
        ack_cnt = '{0, 0};

        // Reset values
        @(negedge clk);
        chk("rst_strobes", {lsu_wait_w, wb_w, ack_w, rd_w, wr_w, tag_w}, 0);
        chk("rst_data", {data_w[0], data_w[1], ifd_w[0], ifd_w[1]}, 0);
        chk("rst_bus", {adr_w[0], wd_w[0]}, 0);
        @(posedge clk); #1;
        a_rst = 1'b0;

        // 16-bit load, tag 1
        rq_start_v = 2'b11; rq_cmd = 0; rq_width = 1; rq_tag = 1; rq_adr = 16'h1234;
        push_ld({1'b1, 16'hABCD});
        @(negedge clk); chk("T1_wait", lsu_wait_w, 2'b00); adv();
        @(negedge clk); chk("T1_rd_c1", {rd_w, wr_w}, 4'b1100); chk("T1_adr_lo", adr_w[0], 16'h1234); adv();
        @(negedge clk); chk("T1_rd_c2", rd_w, 2'b11); chk("T1_adr_hi", adr_w[0], 16'h1235); adv();
        @(negedge clk); chk("T1_wb_c3", wb_w, 2'b11); adv();

        // 16-bit store across the address wrap
        rq_start_v = 2'b11; rq_cmd = 1; rq_width = 1; rq_tag = 0; rq_adr = 16'hFFFF; rq_wdata = 16'hBEEF;
        @(negedge clk); adv();
        @(negedge clk); chk("T2_wr_c1", {wr_w, rd_w}, 4'b1100);
        chk("T2_lo", {adr_w[0], wd_w[0]}, {16'hFFFF, 8'hEF}); adv();
        @(negedge clk); chk("T2_hi", {adr_w[1], wd_w[1]}, {16'h0000, 8'hBE}); adv();
        @(negedge clk); chk("T2_no_wb", {wb_w, wr_w}, 4'b0000); chk("T2_data_held", data_w[0], 16'hABCD); adv();

        // 8-bit load with three wait cycles
        rq_start_v = 2'b11; rq_cmd = 0; rq_width = 0; rq_tag = 0; rq_adr = 16'h0040; mem_rdy = 0;
        push_ld({1'b0, 16'h007F});
        @(negedge clk); adv();
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("T3_rd_held", {rd_w, adr_w[0], adr_w[1]}, {2'b11, 16'h0040, 16'h0040});
            adv();
            if (k == 3) mem_rdy = 1;
        end
        @(negedge clk); chk("T3_wb_c5", wb_w, 2'b11); adv();

        // Simultaneous data and fetch requests
        rq_start_v = 2'b11; if_req_v = 2'b11; rq_adr = 16'h0050; rq_width = 0; rq_tag = 0; if_adr = 16'h2000;
        push_ld({1'b0, 16'h000A});
        push_if(8'h7A);
        @(negedge clk); chk("T4_wait_c0", lsu_wait_w, 2'b10); adv();
        @(negedge clk); chk("T4_wait_c1", lsu_wait_w, 2'b10);
        chk("T4_adr_c1", {adr_w[0], adr_w[1]}, {16'h0050, 16'h2000}); adv();
        @(negedge clk); chk("T4_pulse_c2", {wb_w, ack_w, lsu_wait_w}, 6'b01_10_00); adv();
        @(negedge clk); chk("T4_adr_c3", {adr_w[0], adr_w[1]}, {16'h2000, 16'h0050}); adv();
        @(negedge clk); chk("T4_pulse_c4", {wb_w, ack_w}, 4'b10_01); adv();

        // Data request arrives during a fetch with wait states
        if_req_v = 2'b11; if_adr = 16'h3000; mem_rdy = 0;
        push_if(8'h6A);
        @(negedge clk); chk("T5_wait_c0", lsu_wait_w, 2'b00); adv();
        rq_start_v = 2'b11; rq_cmd = 0; rq_width = 0; rq_tag = 1; rq_adr = 16'h0051;
        push_ld({1'b1, 16'h000B});
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk); chk("T5_wait_fetch", lsu_wait_w, 2'b11); adv();
            if (k == 2) mem_rdy = 1;
        end
        @(negedge clk); chk("T5_ack_accept", {ack_w, lsu_wait_w}, 4'b1100); adv();
        @(negedge clk); chk("T5_adr", adr_w[0], 16'h0051); adv();
        @(negedge clk); chk("T5_wb", wb_w, 2'b11); adv();

        // Reset during the high byte of a 16-bit load
        rq_start_v = 2'b11; rq_cmd = 0; rq_width = 1; rq_tag = 0; rq_adr = 16'h1234;
        @(negedge clk); adv();
        @(negedge clk); chk("T6_rd_c1", rd_w, 2'b11); adv();
        a_rst = 1'b1;
        #1;
        chk("T6_rd_abandon", {rd_w, wr_w}, 4'b0000);
        @(posedge clk); #1;
        a_rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); chk("T6_no_wb", wb_w, 2'b00); adv();
        end
        rq_start_v = 2'b11; rq_width = 0; rq_tag = 1; rq_adr = 16'h0052;
        push_ld({1'b1, 16'h0008});
        @(negedge clk); chk("T6_accept", lsu_wait_w, 2'b00); adv();
        @(negedge clk); adv();
        @(negedge clk); chk("T6_wb", wb_w, 2'b11); adv();
        repeat (3) begin
            @(negedge clk); adv();
        end

        chk("end_queues", ldq_a.size() + ldq_b.size() + ifq_a.size() + ifq_b.size(), 0);
        chk("end_wb_count", {wb_cnt[0][7:0], wb_cnt[1][7:0]}, {8'd5, 8'd5});
        chk("end_ack_count", {ack_cnt[0][7:0], ack_cnt[1][7:0]}, {8'd2, 8'd2});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_bus_sequencer.md
Name: lsu_bus_sequencer

Overview:
Sequences load/store requests issued by the scheduling queue's front stage onto the core's 8-bit external memory bus.
- Splits 16-bit accesses into two little-endian byte cycles.
- Shares the bus with instruction-fetch byte requests.
- Returns load data to the issuing reservation station by tag.
- Throttles the scheduling queue through lsu_wait.

Parameters:
DATA_FIRST, 1, when 1 a pending data request wins over a simultaneous fetch request in IDLE; when 0 fetch wins.

Ports:
clk  in  1  clock
a_rst  in  1  reset, asynchronous, active-high
rq_start  in  1  data request valid (held by the front stage while lsu_wait=1)
rq_cmd  in  1  1=store, 0=load
rq_width  in  1  1=16-bit, 0=8-bit
rq_tag  in  1  issuing station tag (0=rsa, 1=rsb)
rq_adr  in  16  byte address from the AGU
rq_wdata  in  16  store data
lsu_wait  out  1  request not accepted this cycle; front stage must hold
lsu_data_out  out  16  load result
lsu_data_tag  out  1  tag of the returned load
lsu_data_wb  out  1  one-cycle pulse: lsu_data_out/lsu_data_tag valid
if_req  in  1  fetch request, held until if_ack
if_adr  in  16  fetch byte address
if_ack  out  1  one-cycle pulse: if_data valid
if_data  out  8  fetched byte
mem_adr  out  16  bus address
mem_wdata  out  8  bus write data
mem_rd  out  1  bus read strobe
mem_wr  out  1  bus write strobe
mem_rdy  in  1  bus cycle completes this clock
mem_rdata  in  8  bus read data, sampled when mem_rdy=1

Behaviour:
- States: IDLE, D_LO, D_HI, FETCH. Request fields are captured into internal registers on acceptance.
- Reset values: state=IDLE; lsu_data_wb=0, if_ack=0, mem_rd=0, mem_wr=0; lsu_data_out=0, lsu_data_tag=0, if_data=0, mem_adr=0, mem_wdata=0.
- Reset mid-operation abandons any bus cycle. No wb or ack pulse is issued for the abandoned access.

IDLE arbitration:
- Data request accepted if rq_start & (DATA_FIRST | ~if_req). Next state is D_LO.
- Otherwise, fetch accepted if if_req. Next state is FETCH.
- Only one access is accepted per cycle.

lsu_wait:
- Combinational: lsu_wait = rq_start & ~(data accepted this cycle).
- Therefore lsu_wait=1 whenever state≠IDLE, or in IDLE when fetch wins.
- lsu_wait=0 when rq_start=0.

Bus strobes and addresses:
- mem_rd = (D_LO|D_HI) & ~cmd, or FETCH.
- mem_wr = (D_LO|D_HI) & cmd.
- Strobes are decoded from the registered state only. They stay asserted until mem_rdy.
- D_LO: mem_adr=adr, mem_wdata=wdata[7:0].
- D_HI: mem_adr=adr+1 mod 2^16 (0xFFFF wraps to 0x0000), mem_wdata=wdata[15:8].
- FETCH: mem_adr=captured if_adr.

Transitions on mem_rdy:
- D_LO & width16 → D_HI. Load byte goes into data[7:0].
- D_LO & width8 → IDLE.
- D_HI → IDLE. Load byte goes into data[15:8].
- FETCH → IDLE.

Load completion:
- lsu_data_wb pulses in the cycle after the final mem_rdy, together with lsu_data_tag=captured tag.
- 8-bit loads zero-extend: lsu_data_out[15:8]=0.
- Stores never pulse lsu_data_wb.

Fetch completion:
- if_ack pulses in the cycle after mem_rdy, with if_data=captured byte.

Output hold and back-to-back operation:
- lsu_data_out and if_data hold their value between pulses.
- In a wb/ack pulse cycle the block is in IDLE and may accept a new request in that same cycle.

Latency with mem_rdy tied to 1 (accept at cycle 0):
- 8-bit load: wb at cycle 2.
- 16-bit load: wb at cycle 3.
- Fetch: ack at cycle 2.
- Each additional cycle with mem_rdy=0 adds one cycle.

Test Plan:
- Reset, then a 16-bit load (adr=0x1234, tag=1, mem_rdy=1, bus bytes 0xCD then 0xAB) → mem_rd at 0x1234 (cycle 1), 0x1235 (cycle 2); cycle 3: lsu_data_wb=1, lsu_data_out=0xABCD, lsu_data_tag=1; lsu_wait=0 at cycle 0.
- 16-bit store (adr=0xFFFF, wdata=0xBEEF) → mem_wr with 0xFFFF/0xEF, then 0x0000/0xBE; no lsu_data_wb.
- 8-bit load, mem_rdy held low 3 cycles, bus byte 0x7F → mem_rd held 4 cycles at the same address; then wb with data 0x007F.
- Simultaneous rq_start and if_req in IDLE, DATA_FIRST=1 → data accepted, lsu_wait=0; fetch served after data completes; if_ack pulses once. Repeat with DATA_FIRST=0 → fetch first; lsu_wait=1 until IDLE.
- rq_start asserted during FETCH → lsu_wait=1 every cycle until return to IDLE, then accepted in that cycle with lsu_wait=0.
- a_rst asserted during D_HI of a 16-bit load → mem_rd=0 immediately; no wb pulse; next request completes normally.
